// File: rtl/pit_irq_pkg.sv
// Shared constants for the PIT interrupt delivery stage.
package pit_irq_pkg;

  // Default widths
  localparam int PEND_W_DEF     = 4;
  localparam int MISS_W_DEF     = 8;
  localparam int GAP_CYCLES_DEF = 2;

  // Gap counter is sized for the largest legal GAP_CYCLES (15)
  localparam int GAP_W = $clog2(15 + 1);

  // Controller state codes
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ASSERT = 2'd1;
  localparam state_t ST_GAP    = 2'd2;

endpackage

// File: rtl/pit_irq_ctrl_sat_counter.sv
// Width-parameterised up/down counter: saturating increment, no wrap on
// decrement, flag high at the all-ones value.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = &cnt;

  // Count update; simultaneous inc and dec cancel
  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (inc && !dec && !sat)
      cnt <= cnt + 1'b1;
    else if (dec && !inc && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/pit_irq_ctrl.sv
// Interrupt delivery stage after the PIT: pending tick accounting, level irq
// with an enforced low gap after every acknowledge, and loss statistics.
module pit_irq_ctrl
  import pit_irq_pkg::*;
#(
  parameter int PEND_W     = PEND_W_DEF,
  parameter int MISS_W     = MISS_W_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              enable,
  input  logic              mask,
  input  logic              ack,
  input  logic              clear,
  output logic              irq,
  output logic [PEND_W-1:0] pending,
  output logic [MISS_W-1:0] missed,
  output logic              overflow,
  output logic              in_service
);

  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic             tick_acc, ack_acc, pend_sat, miss_sat;
  logic             pend_nxt_nz, lost;

  // irq is only ever high in ASSERT, so it doubles as the ack qualifier
  assign tick_acc = tick && enable && !clear;
  assign ack_acc  = ack && irq && !clear;
  assign lost     = tick_acc && pend_sat && !ack_acc;

  // Whether pending will be non-zero after this edge (ignoring clear)
  assign pend_nxt_nz = tick_acc ? 1'b1 :
                       ack_acc  ? (pending > PEND_W'(1)) :
                                  (pending != '0);

  sat_counter #(.W(PEND_W)) u_pend (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (tick_acc),
    .dec   (ack_acc),
    .cnt   (pending),
    .sat   (pend_sat)
  );

  // Missed count survives clear; only reset zeroes it
  sat_counter #(.W(MISS_W)) u_miss (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (lost && !miss_sat),
    .dec   (1'b0),
    .cnt   (missed),
    .sat   (miss_sat)
  );

  // Next-state selection; clear forces IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (pend_nxt_nz) state_nxt = ST_ASSERT;
      ST_ASSERT: if (ack_acc)     state_nxt = ST_GAP;
      ST_GAP:    if (gap_cnt <= GAP_W'(1))
                   state_nxt = pend_nxt_nz ? ST_ASSERT : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (clear) state_nxt = ST_IDLE;
  end

  // State, gap timer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      irq        <= 1'b0;
      overflow   <= 1'b0;
      in_service <= 1'b0;
    end else begin
      state      <= state_nxt;
      irq        <= (state_nxt == ST_ASSERT) && !mask;
      in_service <= (state_nxt == ST_GAP);
      if (state_nxt == ST_GAP && state != ST_GAP)
        gap_cnt <= GAP_W'(GAP_CYCLES);
      else if (state == ST_GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;
      if (clear)
        overflow <= 1'b0;
      else if (lost)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pit_irq_ctrl.sv
// Directed scoreboard bench for pit_irq_ctrl (default parameters).
module tb_pit_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset, tick, enable, mask, ack, clear;
  logic       irq, overflow, in_service;
  logic [3:0] pending;
  logic [7:0] missed;

  typedef struct {
    string      tag;
    logic       irq;
    logic [3:0] pend;
    logic [7:0] miss;
    logic       ovf;
    logic       svc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pit_irq_ctrl #(.PEND_W(4), .MISS_W(8), .GAP_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .enable     (enable),
    .mask       (mask),
    .ack        (ack),
    .clear      (clear),
    .irq        (irq),
    .pending    (pending),
    .missed     (missed),
    .overflow   (overflow),
    .in_service (in_service)
  );

  // Drive one cycle of inputs, queue the expected post-edge outputs,
  // then pop and compare after the edge.
  task automatic step(input string tag, input logic t, input logic en,
                      input logic m, input logic a, input logic c,
                      input logic r, input logic ei, input logic [3:0] ep,
                      input logic [7:0] em, input logic eo, input logic es);
    exp_t e, x;
    tick = t; enable = en; mask = m; ack = a; clear = c; reset = r;
    e.tag = tag; e.irq = ei; e.pend = ep; e.miss = em; e.ovf = eo; e.svc = es;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    vectors++;
    assert ({irq, pending, missed, overflow, in_service} ===
            {x.irq, x.pend, x.miss, x.ovf, x.svc})
    else begin
      miscompares++;
      $error("FAIL %s: got irq=%b pend=%0d miss=%0d ovf=%b svc=%b, expected irq=%b pend=%0d miss=%0d ovf=%b svc=%b",
             x.tag, irq, pending, missed, overflow, in_service,
             x.irq, x.pend, x.miss, x.ovf, x.svc);
    end
  endtask

  initial begin
    logic [3:0] ep;
    logic [7:0] em;
    tick = 0; enable = 1; mask = 0; ack = 0; clear = 0; reset = 1;

    //             tag        t  en m  a  c  r   irq pend miss ovf svc
    step("reset0",   0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    step("reset1",   0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    step("idle",     0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // disabled tick is dropped and not counted as missed
    step("dis_tick", 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);

    // 1: single tick, ack, 2-cycle gap, back to IDLE
    step("t1_tick",  1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    step("t1_hold",  0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    step("t1_ack",   0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 1);
    step("t1_gap2",  0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    step("t1_idle",  0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // ack while irq low is ignored
    step("t1_ackx",  0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);

    // 2: three ticks, three acks with reassertion after each gap
    step("t2_tk1",   1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    step("t2_tk2",   1, 1, 0, 0, 0, 0,  1, 2, 0, 0, 0);
    step("t2_tk3",   1, 1, 0, 0, 0, 0,  1, 3, 0, 0, 0);
    step("t2_ack1",  0, 1, 0, 1, 0, 0,  0, 2, 0, 0, 1);
    step("t2_gap1",  0, 1, 0, 0, 0, 0,  0, 2, 0, 0, 1);
    step("t2_re1",   0, 1, 0, 0, 0, 0,  1, 2, 0, 0, 0);
    step("t2_ack2",  0, 1, 0, 1, 0, 0,  0, 1, 0, 0, 1);
    step("t2_gap2",  0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 1);
    step("t2_re2",   0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    step("t2_ack3",  0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 1);
    step("t2_gap3",  0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    step("t2_idle",  0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);

    // 3: 17 ticks saturate pending at 15 and lose two
    for (int k = 1; k <= 17; k++) begin
      ep = (k > 15) ? 4'd15 : 4'(k);
      em = (k > 15) ? 8'(k - 15) : 8'd0;
      step($sformatf("t3_sat%0d", k), 1, 1, 0, 0, 0, 0, 1, ep, em, (k > 15), 0);
    end
    step("t3_clear", 0, 1, 0, 0, 1, 0,  0, 0, 2, 0, 0);
    step("t3_idle",  0, 1, 0, 0, 0, 0,  0, 0, 2, 0, 0);

    // 4: tick and ack together with pending=2
    step("t4_tk1",   1, 1, 0, 0, 0, 0,  1, 1, 2, 0, 0);
    step("t4_tk2",   1, 1, 0, 0, 0, 0,  1, 2, 2, 0, 0);
    step("t4_both",  1, 1, 0, 1, 0, 0,  0, 2, 2, 0, 1);
    step("t4_gap2",  0, 1, 0, 0, 0, 0,  0, 2, 2, 0, 1);
    step("t4_re",    0, 1, 0, 0, 0, 0,  1, 2, 2, 0, 0);
    step("t4_clear", 0, 1, 0, 0, 1, 0,  0, 0, 2, 0, 0);

    // 5: masked accumulation, ack ignored, unmask raises irq next cycle
    step("t5_mtk1",  1, 1, 1, 0, 0, 0,  0, 1, 2, 0, 0);
    step("t5_mtk2",  1, 1, 1, 0, 0, 0,  0, 2, 2, 0, 0);
    step("t5_mack",  0, 1, 1, 1, 0, 0,  0, 2, 2, 0, 0);
    step("t5_unmsk", 0, 1, 0, 0, 0, 0,  1, 2, 2, 0, 0);
    step("t5_clear", 0, 1, 0, 0, 1, 0,  0, 0, 2, 0, 0);

    // 6: tick with clear is dropped; reset mid-GAP and mid-ASSERT
    step("t6_tkclr", 1, 1, 0, 0, 1, 0,  0, 0, 2, 0, 0);
    step("t6_tick",  1, 1, 0, 0, 0, 0,  1, 1, 2, 0, 0);
    step("t6_ack",   0, 1, 0, 1, 0, 0,  0, 0, 2, 0, 1);
    step("t6_rstgp", 0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    step("t6_idle",  0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    step("t6_tick2", 1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    step("t6_rstak", 0, 1, 0, 1, 0, 1,  0, 0, 0, 0, 0);
    step("t6_idle2", 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
